// File: rtl/counter_sequencer_if.sv
// Board-side bundle for counter_sequencer: push-button/switch requests in,
// LED count and FSM status out.
interface counter_sequencer_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic             stop;
    logic             step;
    logic             sw0;
    logic             target_en;
    logic [WIDTH-1:0] target;
    logic [WIDTH-1:0] led;
    logic [1:0]       state;
    logic             busy;
    logic             done;

    modport master (
        output start, stop, step, sw0, target_en, target,
        input  led, state, busy, done
    );

    modport slave (
        input  start, stop, step, sw0, target_en, target,
        output led, state, busy, done
    );
endinterface

// File: rtl/counter_sequencer.sv
// Prescaled 4-state up/down LED counter sequencer (IDLE/RUN/STEP/DONE).
// Define COUNTER_SEQ_BOUNCE_EN to reflect at the range ends instead of wrapping.
module counter_sequencer #(
    parameter int DIV   = 4,
    parameter int WIDTH = 4
) (
    input logic clkpulse,
    input logic rst,
    counter_sequencer_if.slave bus
);
    localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        STEP = 2'b10,
        DONE = 2'b11
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] led_q;
    logic [WIDTH-1:0] led_nxt;
    logic [DW-1:0]    div_cnt;
    logic             start_prev, stop_prev, step_prev;
    logic             start_e, stop_e, step_e;
    logic             tick, hit;

    assign start_e = bus.start & ~start_prev;
    assign stop_e  = bus.stop  & ~stop_prev;
    assign step_e  = bus.step  & ~step_prev;
    assign tick    = (div_cnt == DIV_LAST);
    assign hit     = bus.target_en && (led_nxt == bus.target);

`ifdef COUNTER_SEQ_BOUNCE_EN
    logic flip, flip_nxt, dir, count_en, to_idle;

    // At either end the count reflects back one step and the direction flips.
    always_comb begin
        dir      = bus.sw0 ^ flip;
        flip_nxt = flip;
        led_nxt  = led_q + WIDTH'(1);
        if (!dir) begin
            if (led_q == '1) begin
                led_nxt  = led_q - WIDTH'(1);
                flip_nxt = ~flip;
            end
        end else if (led_q == '0) begin
            led_nxt  = WIDTH'(1);
            flip_nxt = ~flip;
        end else begin
            led_nxt = led_q - WIDTH'(1);
        end
    end

    assign count_en = (state_q == STEP) || ((state_q == RUN) && !stop_e && tick);
    assign to_idle  = ((state_q == RUN) && stop_e) || ((state_q == DONE) && stop_e) ||
                      ((state_q == STEP) && !hit);

    always_ff @(posedge clkpulse or posedge rst) begin
        if (rst)           flip <= 1'b0;
        else if (to_idle)  flip <= 1'b0;
        else if (count_en) flip <= flip_nxt;
    end
`else
    always_comb begin
        led_nxt = bus.sw0 ? led_q - WIDTH'(1) : led_q + WIDTH'(1);
    end
`endif

    always_ff @(posedge clkpulse or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            led_q      <= '0;
            div_cnt    <= '0;
            start_prev <= 1'b0;
            stop_prev  <= 1'b0;
            step_prev  <= 1'b0;
        end else begin
            start_prev <= bus.start;
            stop_prev  <= bus.stop;
            step_prev  <= bus.step;
            case (state_q)
                IDLE: begin
                    if (!stop_e) begin
                        if (start_e) begin
                            state_q <= RUN;
                            div_cnt <= '0;
                        end else if (step_e) begin
                            state_q <= STEP;
                        end
                    end
                end
                RUN: begin
                    // A stop edge wins over a coincident tick; prescaler holds.
                    if (stop_e) begin
                        state_q <= IDLE;
                    end else if (tick) begin
                        div_cnt <= '0;
                        led_q   <= led_nxt;
                        if (hit) state_q <= DONE;
                    end else begin
                        div_cnt <= div_cnt + DW'(1);
                    end
                end
                STEP: begin
                    led_q   <= led_nxt;
                    state_q <= hit ? DONE : IDLE;
                end
                DONE: begin
                    if (stop_e) begin
                        state_q <= IDLE;
                    end else if (start_e) begin
                        state_q <= RUN;
                        div_cnt <= '0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.led   = led_q;
    assign bus.state = state_q;
    assign bus.busy  = (state_q == RUN);
    assign bus.done  = (state_q == DONE);
endmodule

// File: doc/counter_sequencer.md
# counter_sequencer

Controller for the 4-bit LED up/down counter path. It sequences the count with a programmable prescaler and a four-state FSM: free-run, single-step, pause, and stop-at-target. Push-button and slide-switch inputs come in, the LED count value goes out. It sits between the board I/O pins and the LED outputs, and replaces the raw clock-per-count scheme.

## Interface
- `DIV`, 4: prescaler period in clocks per count while running; legal range ≥ 1.
- `WIDTH`, 4: count width in bits.
- `clkpulse` input 1: clock; every register updates on its rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `start` input 1: run request; rising-edge detected.
- `stop` input 1: pause request; rising-edge detected.
- `step` input 1: single-count request; rising-edge detected.
- `sw0` input 1: direction; 0 = increment, 1 = decrement.
- `target_en` input 1: 1 enables stop-at-target.
- `target` input `WIDTH`: count value that terminates a run or step.
- `led` output `WIDTH`: current count value.
- `state` output 2: FSM state encoding.
- `busy` output 1: high while in RUN.
- `done` output 1: high while in DONE.

## Operation
- All inputs are synchronous to `clkpulse`. Synchronisation is upstream of this block.
- Edge detect: each of `start`, `stop` and `step` has a previous-value register.
  - edge = in & ~prev.
  - The edge acts on the first posedge that samples the input high.
- Holding an input high produces exactly one edge.
- FSM states: IDLE = 00, RUN = 01, STEP = 10, DONE = 11.
- IDLE:
  - a `start` edge moves to RUN and clears the prescaler;
  - otherwise a `step` edge moves to STEP.
- RUN:
  - the prescaler `div_cnt` counts from 0 to `DIV`-1 and wraps; tick = (`div_cnt` == `DIV`-1);
  - on a tick, `led` updates by ±1 per `sw0`;
  - a `stop` edge moves to IDLE.
- STEP: lasts exactly one cycle. `led` updates by ±1 in that cycle, then the FSM moves to IDLE.
- Target check: applies after any count update in RUN or STEP. If `target_en`=1 and the new `led` equals `target`, the next state is DONE instead of RUN or IDLE.
- DONE:
  - `led` holds;
  - a `start` edge moves to RUN and the count continues past the target;
  - a `stop` edge moves to IDLE;
  - a `step` edge is ignored.
- Arithmetic is modulo 2^`WIDTH`: (2^`WIDTH`-1)+1 = 0 and 0-1 = 2^`WIDTH`-1.
- Priority in the same cycle: `stop` beats `start`, and `start` beats `step`.
  - In RUN, a `stop` edge coinciding with a tick suppresses the count.
- `sw0` and `target` are sampled on the cycle the count update happens. Changing them mid-run takes effect at the next count.
- `busy` = (state == RUN). `done` = (state == DONE).

## Timing
- Reset values: `led` = 0, `state` = IDLE (00), `busy` = 0, `done` = 0. The prescaler and all edge-detect registers are also 0.
- Reset asserted mid-run aborts immediately and asynchronously. The first count after reset requires a new edge.
- `start` edge at posedge N:
  - `state` = RUN after N;
  - first count at posedge N+`DIV`, then every `DIV` clocks;
  - with `DIV`=1, the count updates every cycle starting at N+1.
- `step` edge at posedge N: `state` = STEP after N, `led` updates at N+1, `state` = IDLE (or DONE) after N+1.
- Target hit at posedge M: `state` = DONE and `done` = 1 after M; `led` equals `target`.
- `stop` edge at posedge N in RUN: `state` = IDLE after N. The prescaler holds its value and is cleared on the next `start`.
- All outputs are registered or decoded from registered state, with no combinational path from any input to any output.

## Configuration
- Macro: `COUNTER_SEQ_BOUNCE_EN`.
- Defined:
  - an internal `flip` bit gives effective direction = `sw0` ^ `flip`;
  - counting up at all-ones produces all-ones-1 and toggles `flip`;
  - counting down at 0 produces 1 and toggles `flip`;
  - `flip` clears on reset and on any entry to IDLE.
- Undefined: no `flip` register exists, and the count wraps modulo 2^`WIDTH`.

## Test plan
- Reset then run: reset; `DIV`=4, `sw0`=0, `start` pulse → `led` goes 1, 2, 3 at 4-clock spacing, first at 4 clocks after the edge; `busy`=1.
- Decrement wrap and stop: `led`=0, `sw0`=1, run with `DIV`=1 → `led` goes 15, 14. Then `stop` → `state`=IDLE, `led` holds at 14.
- Step: IDLE, `led`=7, `sw0`=0, hold `step` high for 5 cycles → exactly one update, `led`=8, `state` back to IDLE.
- Target: `target_en`=1, `target`=5, `led`=2, run → `led` stops at 5, `done`=1, `state`=DONE. Then `start` → next count gives `led`=6.
- Simultaneous and reset: `stop` and tick in the same cycle → no count. `start` and `step` edges together in IDLE → RUN. `rst` mid-run → `led`=0, `state`=IDLE immediately.
- Bounce (macro defined): `DIV`=1, `sw0`=0, `led`=14, run → 15, 14, 13. `stop`, then `start` → counting resumes upward.
